nibble_packer: RTL and testbench
================================

NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have `rst_n`, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have `sync`, input, 1 bit: frame start; forces the next accepted nibble to be the low nibble.
REQ-004 SHALL have `in_valid`, input, 1 bit: the Hamming decoder's nibble/error outputs are valid this cycle.
REQ-005 SHALL have `in_data`, input, 4 bits: decoded nibble from the Hamming decoder.
REQ-006 SHALL have `in_err1`, input, 1 bit: single-bit error, corrected by the decoder.
REQ-007 SHALL have `in_err2`, input, 1 bit: double-bit error, uncorrectable.
REQ-008 SHALL have `in_ready`, output, 1 bit: the packer accepts a nibble when `in_valid && in_ready`.
REQ-009 SHALL have `out_valid`, output, 1 bit: assembled byte is available.
REQ-010 SHALL have `out_data`, output, 8 bits: assembled byte, {high nibble, low nibble}.
REQ-011 SHALL have `out_err`, output, 1 bit: either nibble of the byte carried `in_err2`.
REQ-012 SHALL have `out_ready`, input, 1 bit: consumer takes the byte when `out_valid && out_ready`.
REQ-013 SHALL have `cnt_corr`, output, 16 bits: saturating count of accepted nibbles with `in_err1`.
REQ-014 SHALL have `cnt_uncorr`, output, 16 bits: saturating count of accepted nibbles with `in_err2`.

Function
REQ-015 SHALL implement an FSM with two states:
- LOW: awaiting the low nibble.
- HIGH: low nibble held, awaiting the high nibble.
REQ-016 In LOW, an accepted nibble SHALL be stored in the holding register, along with its `in_err2` bit, and the FSM SHALL go to HIGH.
REQ-017 In HIGH, an accepted nibble SHALL load the output register with `out_data={in_data,hold}` and `out_err=hold_err2|in_err2`, and the FSM SHALL go to LOW.
REQ-018 `out_valid` SHALL assert on the cycle after the high nibble is accepted (latency 1 clock).
REQ-019 `in_ready` SHALL be 0 only when state is HIGH, `out_valid=1` and `out_ready=0`; otherwise 1.
REQ-020 When `out_ready=1` and a new high nibble is accepted in the same cycle, the new byte SHALL replace the old one and `out_valid` SHALL stay 1 with no bubble.
REQ-021 `out_valid` SHALL clear when the byte is taken and no new byte loads in that cycle.
REQ-022 `out_data` and `out_err` SHALL hold stable while `out_valid=1` and `out_ready=0`.
REQ-023 `sync=1` SHALL force the state to LOW and discard any held low nibble.
REQ-024 If `sync=1` coincides with an accepted nibble, that nibble SHALL be treated as a low nibble and the state SHALL become HIGH.
REQ-025 The counters SHALL increment once per accepted nibble whose flag is set, and SHALL saturate at 16'hFFFF with no wrap.
REQ-026 `in_err1` and `in_err2` both set on one nibble SHALL increment both counters.
REQ-027 Flags presented while `in_valid=0` or `in_ready=0` SHALL be ignored.

Reset
REQ-028 Asserting `rst_n=0` SHALL immediately force:
- state to LOW;
- the holding register to 0;
- `out_valid`, `out_data`, `out_err` to 0;
- `cnt_corr` and `cnt_uncorr` to 0;
- `in_ready` to 1.
REQ-029 Reset asserted mid-byte SHALL discard the held nibble; the first nibble accepted after reset SHALL be a low nibble.

Configuration
REQ-030 SHALL support the macro `NIBBLE_PACKER_DROP_BAD_EN`.
- Defined: a completed byte with `out_err=1` SHALL NOT load the output register (`out_valid` is never raised for it), and the FSM SHALL still return to LOW.
- Undefined: such bytes SHALL be delivered with `out_err=1`.
- Counters SHALL behave identically in both builds.

Structure
REQ-031 Package `nibble_packer_pkg` SHALL hold the FSM state enum (LOW, HIGH) and the constant CNT_W=16.
REQ-032 The sub-module `sat_counter` (CNT_W bits, increment enable, async active-low reset) SHALL be instantiated twice, once per error counter.

Verification
REQ-033 The bench SHALL cover:
- Nibbles 0x1 then 0x4 with `out_ready=1`: `out_data=0x41` and `out_err=0` one cycle after the second nibble; `out_valid` high for 1 cycle.
- `out_ready=0`, nibbles 0xE,0x1,0x2,0x3: byte 0x1E held; `in_ready=0` while HIGH with 0x2 held; raising `out_ready` gives 0x1E then 0x32 back-to-back.
- Nibble 0x4 with `in_err2=1`, then 0x5: without the macro, 0x54 with `out_err=1`; with the macro, no `out_valid`; `cnt_uncorr=1` in both builds.
- Nibble 0x7, `sync` pulse, nibbles 0x9,0xA: single byte 0xA9; 0x7 discarded.
- 65540 nibbles with `in_err1=1`: `cnt_corr=0xFFFF` with no wrap; `rst_n` pulse mid-stream clears everything and the next pair packs correctly.

Source files
------------

// File: rtl/nibble_packer_pkg.sv
// Shared types and constants for the nibble packer slice.
// Holds the two-state FSM encoding and the error counter width.
package nibble_packer_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter
    import nibble_packer_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/nibble_packer.sv
// Packs pairs of Hamming-decoded nibbles into bytes {high, low} with error tracking.
// Build option: define NIBBLE_PACKER_DROP_BAD_EN to suppress bytes whose out_err would be set.
//
// state | meaning
// ------+---------------------------------------------
// LOW   | awaiting the low nibble
// HIGH  | low nibble held, awaiting the high nibble
module nibble_packer
    import nibble_packer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             in_err1,
    input  logic             in_err2,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_err,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    state_e     state_q, state_d;
    logic [3:0] hold_q;
    logic       hold_err_q;
    logic       out_valid_q;
    logic [7:0] out_data_q;
    logic       out_err_q;

    logic       accept;
    logic       take_low;
    logic       load_pair;
    logic       load_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // sync overrides the current state, so an accepted nibble under sync is always a low nibble
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = take_low ? HIGH : LOW;
        end else if (sync) begin
            state_d = LOW;
        end
    end

    always_comb begin
        in_ready  = !((state_q == HIGH) && out_valid_q && !out_ready);
        accept    = in_valid && in_ready;
        take_low  = sync || (state_q == LOW);
        load_pair = accept && !take_low;
`ifdef NIBBLE_PACKER_DROP_BAD_EN
        load_out  = load_pair && !(hold_err_q || in_err2);
`else
        load_out  = load_pair;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= 4'h0;
            hold_err_q <= 1'b0;
        end else if (accept && take_low) begin
            hold_q     <= in_data;
            hold_err_q <= in_err2;
        end else if (sync) begin
            hold_q     <= 4'h0;
            hold_err_q <= 1'b0;
        end
    end

    // A new byte may replace the one being consumed in the same cycle, so loading wins over clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_err_q   <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {in_data, hold_q};
            out_err_q   <= hold_err_q | in_err2;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    sat_counter #(.W(CNT_W)) u_cnt_corr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (accept && in_err1),
        .cnt_o (cnt_corr)
    );

    sat_counter #(.W(CNT_W)) u_cnt_uncorr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (accept && in_err2),
        .cnt_o (cnt_uncorr)
    );

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: directed scenarios plus random traffic
// compared against a transaction-level model of pairing, buffering and error counting.
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_err1;
    logic        in_err2;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_err;
    logic        out_ready;
    logic [15:0] cnt_corr;
    logic [15:0] cnt_uncorr;

    int checks = 0;
    int fails  = 0;

    // model state: pending low nibble and one-deep output buffer
    bit         m_pend;
    logic [3:0] m_nib;
    bit         m_perr;
    bit         m_full;
    logic [7:0] m_byte;
    bit         m_oerr;
    int         m_corr;
    int         m_unc;

    nibble_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_err1    (in_err1),
        .in_err2    (in_err2),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_ready  (out_ready),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pend = 0; m_nib = 4'h0; m_perr = 0;
        m_full = 0; m_byte = 8'h00; m_oerr = 0;
        m_corr = 0; m_unc = 0;
    endtask

    task automatic cycle(input bit s, input bit v, input logic [3:0] d, input bit e1,
                         input bit e2, input bit ordy, input bit do_chk);
        bit exp_rdy;
        bit acc;
        bit bad;
        @(negedge clk);
        sync = s; in_valid = v; in_data = d; in_err1 = e1; in_err2 = e2; out_ready = ordy;
        #1;
        exp_rdy = !(m_pend && m_full && !ordy);
        if (do_chk) begin
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, m_full);
            if (m_full) begin
                chk("out_data", out_data, m_byte);
                chk("out_err", out_err, m_oerr);
            end
            chk("cnt_corr", cnt_corr, m_corr);
            chk("cnt_uncorr", cnt_uncorr, m_unc);
        end
        acc = v && exp_rdy;
        if (m_full && ordy) m_full = 0;
        if (acc) begin
            if (e1) m_corr = (m_corr < 65535) ? m_corr + 1 : 65535;
            if (e2) m_unc  = (m_unc  < 65535) ? m_unc  + 1 : 65535;
            if (s || !m_pend) begin
                m_pend = 1; m_nib = d; m_perr = e2;
            end else begin
                m_pend = 0;
                bad = m_perr | e2;
`ifdef NIBBLE_PACKER_DROP_BAD_EN
                if (!bad) begin
                    m_full = 1; m_byte = {d, m_nib}; m_oerr = bad;
                end
`else
                m_full = 1; m_byte = {d, m_nib}; m_oerr = bad;
`endif
            end
        end else if (s) begin
            m_pend = 0;
        end
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 0, 4'h0, 0, 0, ordy, 1);
    endtask

    task automatic nib(input logic [3:0] d, input bit e1, input bit e2, input bit ordy);
        cycle(0, 1, d, e1, e2, ordy, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sync = 0; in_valid = 0; in_data = 4'h0; in_err1 = 0; in_err2 = 0; out_ready = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_cnt_corr", cnt_corr, 16'h0000);
        chk("rst_cnt_uncorr", cnt_uncorr, 16'h0000);
        chk("rst_in_ready", in_ready, 1'b1);
        model_clear();
        @(negedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        rst_n = 0; sync = 0; in_valid = 0; in_data = 4'h0;
        in_err1 = 0; in_err2 = 0; out_ready = 1;
        model_clear();
        #3;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_in_ready", in_ready, 1'b1);
        chk("init_cnt_corr", cnt_corr, 16'h0000);
        @(negedge clk);
        #1 rst_n = 1;

        // simple pair 0x1, 0x4
        nib(4'h1, 0, 0, 1);
        nib(4'h4, 0, 0, 1);
        idle(1);
        chk("pair41_valid", out_valid, 1'b1);
        chk("pair41_data", out_data, 8'h41);
        chk("pair41_err", out_err, 1'b0);
        idle(1);
        chk("pair41_one_cycle", out_valid, 1'b0);

        // backpressure: 0x1E held, 0x2 pending, 0x3 stalled
        nib(4'hE, 0, 0, 0);
        nib(4'h1, 0, 0, 0);
        nib(4'h2, 0, 0, 0);
        nib(4'h3, 0, 0, 0);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_hold_1e", out_data, 8'h1E);
        nib(4'h3, 0, 0, 0);
        chk("bp_still_1e", out_data, 8'h1E);
        nib(4'h3, 0, 0, 1);
        chk("bp_take_1e", out_data, 8'h1E);
        idle(1);
        chk("bp_next_valid", out_valid, 1'b1);
        chk("bp_next_32", out_data, 8'h32);
        idle(1);
        chk("bp_drained", out_valid, 1'b0);

        // uncorrectable error on the low nibble
        do_reset();
        nib(4'h4, 0, 1, 1);
        nib(4'h5, 0, 0, 1);
        idle(1);
`ifdef NIBBLE_PACKER_DROP_BAD_EN
        chk("bad_dropped", out_valid, 1'b0);
`else
        chk("bad_valid", out_valid, 1'b1);
        chk("bad_data", out_data, 8'h54);
        chk("bad_err", out_err, 1'b1);
`endif
        chk("bad_cnt_uncorr", cnt_uncorr, 16'h0001);
        idle(1);

        // sync discards a held low nibble
        nib(4'h7, 0, 0, 1);
        cycle(1, 0, 4'h0, 0, 0, 1, 1);
        nib(4'h9, 0, 0, 1);
        nib(4'hA, 0, 0, 1);
        idle(1);
        chk("sync_valid", out_valid, 1'b1);
        chk("sync_data", out_data, 8'hA9);
        idle(1);
        chk("sync_single", out_valid, 1'b0);

        // sync coinciding with an accepted nibble restarts the pair on that nibble
        nib(4'h6, 0, 0, 1);
        cycle(1, 1, 4'hB, 0, 0, 1, 1);
        nib(4'hC, 0, 0, 1);
        idle(1);
        chk("sync_acc_data", out_data, 8'hCB);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(15) == 0), ($urandom_range(3) != 0), 4'($urandom_range(15)),
                  ($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(2) != 0), 1);
        end
        idle(1);
        idle(1);

        // saturation of the corrected-error counter
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            cycle(0, 1, 4'($urandom_range(15)), 1, 0, 1, 0);
        end
        idle(1);
        chk("sat_cnt_corr", cnt_corr, 16'hFFFF);
        chk("sat_cnt_uncorr", cnt_uncorr, 16'h0000);

        // reset mid-byte, then a fresh pair
        nib(4'h8, 1, 0, 1);
        chk("sat_no_wrap", cnt_corr, 16'hFFFF);
        do_reset();
        nib(4'h3, 0, 0, 1);
        nib(4'hC, 0, 0, 1);
        idle(1);
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_data", out_data, 8'hC3);
        idle(1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
